// File: rtl/baccarat_pkg.sv
// Shared definitions for the baccarat table controller: state encoding,
// tableau thresholds and rank-to-value conversion.
package baccarat_pkg;

    typedef enum logic [3:0] {
        S_START = 4'd0,
        S_P1    = 4'd1,
        S_D1    = 4'd2,
        S_P2    = 4'd3,
        S_D2    = 4'd4,
        S_EVAL  = 4'd5,
        S_P3    = 4'd6,
        S_BANK  = 4'd7,
        S_D3    = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    localparam logic [3:0] NATURAL_MIN     = 4'd8;
    localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
    localparam logic [3:0] BANKER_DRAW_MAX = 4'd5;

    // Load strobe bit positions: {dcard3, dcard2, dcard1, pcard3, pcard2, pcard1}
    localparam int unsigned LD_P1 = 0;
    localparam int unsigned LD_P2 = 1;
    localparam int unsigned LD_P3 = 2;
    localparam int unsigned LD_D1 = 3;
    localparam int unsigned LD_D2 = 4;
    localparam int unsigned LD_D3 = 5;

    // Ten and face cards count zero; rank 0 (empty slot) is also zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank <= 4'd9) ? rank : 4'd0;
    endfunction

    function automatic logic [5:0] load_mask(input state_t st);
        logic [5:0] m;
        m = '0;
        case (st)
            S_P1:    m[LD_P1] = 1'b1;
            S_D1:    m[LD_D1] = 1'b1;
            S_P2:    m[LD_P2] = 1'b1;
            S_D2:    m[LD_D2] = 1'b1;
            S_P3:    m[LD_P3] = 1'b1;
            S_D3:    m[LD_D3] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card tableau: decides whether the banker draws given its
// two-card score and the value of the player's third card.
module banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_controller.sv
// Baccarat deal sequencer: issues card-load strobes in dealing order, applies
// the player/banker third-card rules and lights the winner when done.
module deal_controller
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore_in,
    input  logic [3:0] dscore_in,
    input  logic [3:0] pcard3_in,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [3:0] state_out
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_load;
    logic       w_bank_draw;
    logic       w_natural;
    logic       w_done;

    banker_rule u_banker_rule (
        .dscore (dscore_in),
        .v      (card_value(pcard3_in)),
        .draw   (w_bank_draw)
    );

    assign w_natural = (pscore_in >= NATURAL_MIN) || (dscore_in >= NATURAL_MIN);

    always_comb begin
        w_next = S_START;
        case (r_state)
            S_START: w_next = S_P1;
            S_P1:    w_next = S_D1;
            S_D1:    w_next = S_P2;
            S_P2:    w_next = S_D2;
            S_D2:    w_next = S_EVAL;
            S_EVAL: begin
                if (w_natural)
                    w_next = S_DONE;
                else if (pscore_in <= PLAYER_DRAW_MAX)
                    w_next = S_P3;
                else if (dscore_in <= BANKER_DRAW_MAX)
                    w_next = S_D3;
                else
                    w_next = S_DONE;
            end
            S_P3:    w_next = S_BANK;
            S_BANK:  w_next = w_bank_draw ? S_D3 : S_DONE;
            S_D3:    w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_START;
        endcase
    end

    // Strobes are registered from the next state so they align with r_state
    // while still being a pure function of the state register.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_START;
            r_load  <= '0;
        end else begin
            r_state <= w_next;
            r_load  <= load_mask(w_next);
        end
    end

    assign w_done = (r_state == S_DONE);

    assign load_pcard1      = r_load[LD_P1];
    assign load_pcard2      = r_load[LD_P2];
    assign load_pcard3      = r_load[LD_P3];
    assign load_dcard1      = r_load[LD_D1];
    assign load_dcard2      = r_load[LD_D2];
    assign load_dcard3      = r_load[LD_D3];
    assign player_win_light = w_done && (pscore_in >= dscore_in);
    assign dealer_win_light = w_done && (dscore_in >= pscore_in);
    assign state_out        = r_state;

endmodule

// File: tb/tb_deal_controller.sv
// Scoreboard bench for deal_controller with a behavioural card datapath model.
module tb_deal_controller;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] pscore_in, dscore_in, pcard3_in;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
    logic [3:0] state_out;

    int checks = 0;
    int errors = 0;

    // Strobe encodings {d3,d2,d1,p3,p2,p1}
    localparam logic [5:0] E_P1 = 6'b000001;
    localparam logic [5:0] E_P2 = 6'b000010;
    localparam logic [5:0] E_P3 = 6'b000100;
    localparam logic [5:0] E_D1 = 6'b001000;
    localparam logic [5:0] E_D2 = 6'b010000;
    localparam logic [5:0] E_D3 = 6'b100000;

    logic [5:0] exp_q[$];

    // Deck dealt by the model: ranks for p1,d1,p2,d2,p3,d3
    logic [3:0] deck [6];
    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
    int         edges;

    deal_controller dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore_in        (pscore_in),
        .dscore_in        (dscore_in),
        .pcard3_in        (pcard3_in),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .state_out        (state_out)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    function automatic logic [3:0] val(input logic [3:0] r);
        return (r <= 4'd9) ? r : 4'd0;
    endfunction

    function automatic logic [3:0] score3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        int s;
        s = (int'(val(a)) + int'(val(b)) + int'(val(c))) % 10;
        return 4'(s);
    endfunction

    // Card datapath model: latch on the edge that leaves the load state.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            pc1 <= '0; pc2 <= '0; pc3 <= '0;
            dc1 <= '0; dc2 <= '0; dc3 <= '0;
            edges <= 0;
        end else begin
            edges <= edges + 1;
            if (load_pcard1) pc1 <= deck[0];
            if (load_dcard1) dc1 <= deck[1];
            if (load_pcard2) pc2 <= deck[2];
            if (load_dcard2) dc2 <= deck[3];
            if (load_pcard3) pc3 <= deck[4];
            if (load_dcard3) dc3 <= deck[5];
        end
    end

    assign pscore_in = score3(pc1, pc2, pc3);
    assign dscore_in = score3(dc1, dc2, dc3);
    assign pcard3_in = pc3;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // Monitor: every strobe the DUT presents must match the next expected one.
    always @(negedge slow_clock) begin
        logic [5:0] w;
        logic [5:0] e;
        if (resetb) begin
            w = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};
            if (w != 6'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe got %b exp none at state %0d", w, state_out);
                end else begin
                    e = exp_q.pop_front();
                    if (w != e) begin
                        errors++;
                        $display("FAIL strobe got %b exp %b at state %0d", w, e, state_out);
                    end
                end
            end
        end
    end

    task automatic load_deck(input logic [3:0] p1, input logic [3:0] d1, input logic [3:0] p2,
                             input logic [3:0] d2, input logic [3:0] p3, input logic [3:0] d3);
        deck[0] = p1; deck[1] = d1; deck[2] = p2;
        deck[3] = d2; deck[4] = p3; deck[5] = d3;
    endtask

    task automatic start_deal();
        @(negedge slow_clock);
        resetb = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    task automatic wait_done(input string name, input int exp_edges, input logic exp_pl, input logic exp_dl);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge slow_clock);
            #1;
            if (state_out == 4'd9) begin
                seen = 1;
                break;
            end
        end
        check({name, "_done_state"}, int'(state_out), 9);
        if (seen) begin
            check({name, "_edges"}, edges, exp_edges);
            check({name, "_player_light"}, int'(player_win_light), int'(exp_pl));
            check({name, "_dealer_light"}, int'(dealer_win_light), int'(exp_dl));
        end
        check({name, "_strobes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        resetb = 1'b0;
        load_deck(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        #12;
        check("reset_state", int'(state_out), 0);
        check("reset_loads", int'({load_dcard3, load_dcard2, load_dcard1,
                                   load_pcard3, load_pcard2, load_pcard1}), 0);
        check("reset_lights", int'({player_win_light, dealer_win_light}), 0);

        // Natural: player 3+5=8, dealer 1+2=3
        load_deck(4'd3, 4'd1, 4'd5, 4'd2, 4'd0, 4'd0);
        exp_q = '{E_P1, E_D1, E_P2, E_D2};
        start_deal();
        wait_done("natural", 6, 1'b1, 1'b0);

        // Player stands on 6, dealer 4 draws a 3 -> 7
        load_deck(4'd6, 4'd2, 4'd10, 4'd2, 4'd0, 4'd3);
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_D3};
        start_deal();
        wait_done("stand_draw", 7, 1'b0, 1'b1);

        // Banker 6 vs player third 7: draws (player 9, dealer 7)
        load_deck(4'd1, 4'd3, 4'd1, 4'd3, 4'd7, 4'd1);
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_P3, E_D3};
        start_deal();
        wait_done("bank6_draw", 9, 1'b1, 1'b0);

        // Banker 6 vs queen (value 0): stands (player 2, dealer 6)
        load_deck(4'd1, 4'd3, 4'd1, 4'd3, 4'd12, 4'd1);
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_P3};
        start_deal();
        wait_done("bank6_stand", 8, 1'b0, 1'b1);

        // Banker 3 vs 8: stands (player 8, dealer 3)
        load_deck(4'd10, 4'd1, 4'd13, 4'd2, 4'd8, 4'd4);
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_P3};
        start_deal();
        wait_done("bank3_stand", 8, 1'b1, 1'b0);

        // Banker 3 vs king (value 0): draws a 4 (player 0, dealer 7)
        load_deck(4'd10, 4'd1, 4'd13, 4'd2, 4'd13, 4'd4);
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_P3, E_D3};
        start_deal();
        wait_done("bank3_draw", 9, 1'b0, 1'b1);

        // Tie at 5-5; lights hold with no further strobes
        load_deck(4'd2, 4'd2, 4'd3, 4'd3, 4'd10, 4'd9);
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_P3};
        start_deal();
        wait_done("tie", 8, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge slow_clock);
            #1;
            check("tie_hold_lights", int'({player_win_light, dealer_win_light}), 3);
            check("tie_hold_state", int'(state_out), 9);
        end

        // Asynchronous reset while in S_P3
        load_deck(4'd1, 4'd3, 4'd1, 4'd3, 4'd7, 4'd1);
        exp_q = '{E_P1, E_D1, E_P2, E_D2};
        start_deal();
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge slow_clock);
                #1;
                if (state_out == 4'd6) begin
                    seen = 1;
                    break;
                end
            end
            check("rst_reach_p3", int'(state_out), 6);
            check("rst_p3_strobe", int'(load_pcard3), 1);
        end
        #1;
        resetb = 1'b0;
        #1;
        check("rst_async_load_pcard3", int'(load_pcard3), 0);
        check("rst_async_state", int'(state_out), 0);
        check("rst_async_lights", int'({player_win_light, dealer_win_light}), 0);
        check("rst_strobes_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge slow_clock);
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_P3, E_D3};
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        check("rst_restart_state", int'(state_out), 1);
        check("rst_restart_load_pcard1", int'(load_pcard1), 1);
        wait_done("rst_rerun", 9, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
